// File: rtl/ram8_fifo_ctrl.sv
// Valid/ready FIFO controller around a single-port ram8: 8 RAM entries plus a
// registered head stage give 9 words of storage, fetch has priority over push.
module ram8_fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [ADDR_W:0]   count
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;

  logic slot_free, ram_empty, fetch, bypass, push, ram_push;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    ram_empty = (ram_cnt_q == '0);
    fetch     = !ram_empty && slot_free;
    bypass    = ram_empty && slot_free;
    // ram_cnt never exceeds 2**ADDR_W, so its MSB alone means "RAM full".
    in_ready  = rst_n && (bypass || (!fetch && !ram_cnt_q[ADDR_W]));
    push      = in_valid && in_ready;
    ram_push  = push && !bypass;

    ram_load    = ram_push;
    ram_address = ram_push ? wr_ptr_q : rd_ptr_q;
    ram_in      = in_data;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (fetch) begin
      out_data_d  = ram_out;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ram_cnt_d   = ram_cnt_q - 1'b1;
    end else if (push && bypass) begin
      // Covers pop-and-replace: the head is overwritten and stays valid.
      out_data_d  = in_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // fetch forces in_ready low, so a RAM push never overlaps a fetch.
    if (ram_push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = ram_cnt_q + {{ADDR_W{1'b0}}, out_valid_q};

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Bench for ram8_fifo_ctrl: behavioural ram8, directed cycle steps, and a
// scoreboard queue drained by an independent output monitor.
module tb_ram8_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ram_in;
  logic [2:0]  ram_address;
  logic        ram_load;
  logic [15:0] ram_out;
  logic [3:0]  count;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] mem [8];

  ram8_fifo_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
    .ram_out(ram_out), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ram8 model: synchronous write, combinational read
  initial for (int i = 0; i < 8; i++) mem[i] = 16'h0;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // Monitor: every handshake on the output side must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL pop_unexpected: got 0x%0h want none", out_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("pop_data", int'(out_data), int'(e));
      end
    end
  end

  // One clock of stimulus; e_addr/e_cnt < 0 skips that check.
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                      input logic e_rdy, input logic e_load,
                      input int e_addr, input int e_cnt, input string tag);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    chk({tag, ".in_ready"}, int'(in_ready), int'(e_rdy));
    chk({tag, ".ram_load"}, int'(ram_load), int'(e_load));
    if (e_addr >= 0) chk({tag, ".ram_address"}, int'(ram_address), e_addr);
    if (e_cnt >= 0)  chk({tag, ".count"}, int'(count), e_cnt);
    if (iv && e_rdy) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready",  int'(in_ready),  0);
    chk("rst.ram_load",  int'(ram_load),  0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.count",     int'(count),     0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // bypass into an empty FIFO, popped the next cycle
    step(1, 16'h1234, 1, 1, 0, 0, 0, "byp");
    step(0, 16'h0000, 1, 1, 0, 0, 1, "byp2");

    // fill: first word to head, next eight to RAM 0..7
    step(1, 16'h0001, 0, 1, 0, 0, 0, "fill_head");
    for (int k = 2; k <= 9; k++)
      step(1, 16'(k), 0, 1, 1, k - 2, k - 1, "fill");
    step(1, 16'hDEAD, 0, 0, 0, 0, 9, "full");

    // drain: one word per cycle
    for (int j = 0; j < 8; j++)
      step(0, 16'h0000, 1, 0, 0, j, 9 - j, "drain");
    step(0, 16'h0000, 1, 1, 0, 0, 1, "drain_last");

    // build ram_cnt=3 behind a stalled head
    step(1, 16'h0011, 0, 1, 0, 0, 0, "cf_head");
    for (int k = 0; k < 3; k++)
      step(1, 16'(16'h12 + k), 0, 1, 1, k, k + 1, "cf_fill");
    // fetch wins the port: push refused, address is rd_ptr
    step(1, 16'h0015, 1, 0, 0, 0, 4, "conflict");
    step(1, 16'h0015, 0, 1, 1, 3, 3, "conflict_next");

    // wr_ptr wraps 7 -> 0
    for (int k = 0; k < 5; k++)
      step(1, 16'(16'h16 + k), 0, 1, 1, (4 + k) % 8, 4 + k, "wrap");
    step(1, 16'h001B, 0, 0, 0, 1, 9, "wrap_full");

    for (int k = 0; k < 4; k++)
      step(0, 16'h0000, 1, 0, 0, 1 + k, 9 - k, "pdrain");
    step(0, 16'h0000, 0, 1, 0, 5, 5, "cnt5");

    // async reset between edges
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("arst.count",     int'(count),     0);
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.in_ready",  int'(in_ready),  0);
    chk("arst.ram_load",  int'(ram_load),  0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    step(1, 16'h0077, 1, 1, 0, 0, 0, "post_rst");
    step(0, 16'h0000, 1, 1, 0, 0, 1, "post_rst2");

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram8_fifo_ctrl.md
Name: ram8_fifo_ctrl

Overview:
Upstream/downstream controller that turns one ram8 into an 8-entry FIFO with valid/ready handshakes on both sides. It drives ram8's in/address/load and consumes its combinational out. A registered output head stage adds one more entry, so total capacity is 9 words. ram8 has a single address port, so each cycle is either one RAM write or one RAM read-fetch, never both.

Parameters:
WIDTH, 16, data word width; must match ram8's 16-bit word.
ADDR_W, 3, RAM address width; 2**ADDR_W = 8 RAM entries (fixed by ram8).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_data  input  16  word offered by the producer.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  controller accepts in_data this cycle (combinational).
out_data  output  16  head-of-FIFO word (registered).
out_valid  output  1  out_data holds a valid word (registered).
out_ready  input  1  consumer takes out_data this cycle.
ram_in  output  16  to ram8 in; equals in_data.
ram_address  output  3  to ram8 address.
ram_load  output  1  to ram8 load.
ram_out  input  16  from ram8 out (combinational read of ram_address).
count  output  4  total occupancy 0..9 (RAM entries plus head register).

Behaviour:
- State: wr_ptr[2:0], rd_ptr[2:0], ram_cnt[3:0] (0..8), out_valid, out_data.
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, ram_cnt=0, out_valid=0, out_data=0, count=0. While rst_n=0, in_ready=0 and ram_load=0 combinationally.
- Combinational terms:
  - slot_free = !out_valid || out_ready
  - fetch = (ram_cnt>0) && slot_free
  - bypass = (ram_cnt==0) && slot_free
  - in_ready = bypass || (!fetch && ram_cnt<8)
  - push = in_valid && in_ready
- Port arbitration, fetch before push:
  - fetch=1: ram_address=rd_ptr, ram_load=0.
  - push && !bypass: ram_address=wr_ptr, ram_load=1.
  - Otherwise ram_address=rd_ptr, ram_load=0.
  - ram_in=in_data at all times.
- Edge updates:
  - fetch: out_data<=ram_out, out_valid<=1, rd_ptr<=rd_ptr+1 (mod 8), ram_cnt-=1.
  - push && bypass: out_data<=in_data, out_valid<=1; RAM untouched.
  - push && !bypass: RAM write at wr_ptr, wr_ptr<=wr_ptr+1 (mod 8), ram_cnt+=1.
  - out_valid && out_ready && !fetch && !(push && bypass): out_valid<=0.
  - fetch and a RAM push cannot coincide. Pop plus bypass push in the same cycle: the head is replaced by the new word and out_valid stays 1.
- count = ram_cnt + out_valid, registered-derived with no combinational input path.
- Head states: EMPTY (out_valid=0, ram_cnt=0), HEAD (out_valid=1, ram_cnt=0), BUFFERED (ram_cnt>0).
  - EMPTY→HEAD: bypass push.
  - HEAD→BUFFERED: push while the head is stalled.
  - BUFFERED→HEAD: fetch with ram_cnt=1 and no push.
  - HEAD→EMPTY: pop with no push.
- Latency:
  - Word pushed into EMPTY: out_valid the next cycle.
  - Word written to RAM: reaches head at the earliest one cycle after slot_free.
- Full: ram_cnt=8 with head stalled gives in_ready=0 and count=9.
- Fairness: while fetch=1, in_ready=0, so continuous pushes cannot starve the head.
- Data order is strict FIFO; pointers wrap 7→0 silently.
- in_ready depends combinationally on out_ready. Producers must not make in_valid depend on in_ready.
- Reset mid-operation discards all contents immediately. RAM contents are left stale but unreachable.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → in_ready=0, ram_load=0, out_valid=0, count=0. Release rst_n; first push lands in the head.
- Bypass: from EMPTY push 0x1234 with out_ready=1 → next cycle out_valid=1, out_data=0x1234, ram_load never asserted, count=1.
- Fill: out_ready=0, push 0x0001..0x0009 → RAM writes at addresses 0..7, count reaches 9, in_ready=0. A further in_valid is not accepted.
- Drain and wrap:
  - From full, out_ready=1 → out_data sequence 0x0001..0x0009, one word per cycle from the second word.
  - Then push 8 more words → wr_ptr wraps 7→0 and order is preserved.
- Conflict: ram_cnt=3, out_valid=1, out_ready=1, in_valid=1 → in_ready=0 that cycle, ram_address=rd_ptr, fetch occurs. Push is accepted the next cycle.
- Async reset: assert rst_n=0 between clock edges with count=5 → count=0 and out_valid=0 immediately, without waiting for a clock edge.
